// File: rtl/spi_device_pkg.sv
// Shared types and shifter target counts for the SPI device TX scheduler.
package spi_device_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREFETCH,
    ST_LOAD,
    ST_SHIFT
  } sched_state_e;

  localparam logic [7:0] SPI_TGT_SINGLE = 8'd31;
  localparam logic [7:0] SPI_TGT_QUAD   = 8'd7;

endpackage

// File: rtl/spi_tx_hold.sv
// One-entry holding register between the word source and the shifter load port.
module spi_tx_hold #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              sclk,
  input  logic              clr,
  input  logic              load,
  input  logic              take,
  input  logic [DATA_W-1:0] din,
  input  logic [DATA_W-1:0] bypass_data,
  output logic              full,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] data_q;

  always_ff @(posedge sclk) begin
    if (clr) begin
      full   <= 1'b0;
      data_q <= '0;
    end else if (load) begin
      full   <= 1'b1;
      data_q <= din;
    end else if (take) begin
      full   <= 1'b0;
    end
  end

  // An empty hold passes the source word straight through.
  assign dout = full ? data_q : bypass_data;

endmodule

// File: rtl/spi_device_tx_sched.sv
// Arbitrates register-read and FIFO-stream requesters onto the TX shifter and
// feeds one prefetched word per shifter word boundary.
module spi_device_tx_sched
  import spi_device_pkg::*;
#(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       LEN_W    = 8,
  parameter logic [DATA_W-1:0] PAD_WORD = '0
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic              cs,
  input  logic              en_quad,
  input  logic              reg_req,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              reg_gnt,
  input  logic              stream_req,
  input  logic [LEN_W-1:0]  stream_len,
  output logic              stream_gnt,
  input  logic [DATA_W-1:0] stream_data,
  input  logic              stream_valid,
  output logic              stream_ready,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_data_valid,
  output logic [7:0]        tx_counter,
  output logic              tx_counter_upd,
  output logic              tx_en_quad,
  input  logic              tx_done,
  output logic              busy,
  output logic              xfer_done,
  output logic              underflow
);

  sched_state_e      state;
  logic              src_stream;
  logic [LEN_W-1:0]  send_left;
  logic [LEN_W-1:0]  fetch_left;
  logic              active;
  logic              pop;
  logic              word_edge;
  logic              bypass;
  logic              hold_full;
  logic              hold_load;
  logic              hold_take;
  logic [DATA_W-1:0] hold_din;
  logic [DATA_W-1:0] hold_dout;

  always_comb begin
    active       = !rst && !cs;
    reg_gnt      = active && (state == ST_IDLE) && reg_req;
    stream_gnt   = active && (state == ST_IDLE) && !reg_req && stream_req;
    busy         = (state != ST_IDLE);
    stream_ready = 1'b0;
    if (active && state == ST_PREFETCH)
      stream_ready = 1'b1;
    else if (active && state == ST_SHIFT)
      stream_ready = src_stream && !hold_full && (fetch_left != '0);
    pop            = stream_ready && stream_valid;
    word_edge      = active && (state == ST_SHIFT) && tx_done && (send_left != '0);
    bypass         = word_edge && !hold_full && pop;
    tx_counter_upd = active && (state == ST_LOAD);
    tx_data_valid  = word_edge || tx_counter_upd;
    tx_data        = '0;
    if (tx_data_valid)
      tx_data = (hold_full || bypass) ? hold_dout : PAD_WORD;
    hold_load = reg_gnt || (pop && !bypass);
    hold_take = tx_data_valid && hold_full;
    hold_din  = reg_gnt ? reg_rdata : stream_data;
  end

  spi_tx_hold #(.DATA_W(DATA_W)) u_hold (
    .sclk        (sclk),
    .clr         (rst || cs),
    .load        (hold_load),
    .take        (hold_take),
    .din         (hold_din),
    .bypass_data (stream_data),
    .full        (hold_full),
    .dout        (hold_dout)
  );

  always_ff @(posedge sclk) begin
    if (rst) begin
      state      <= ST_IDLE;
      src_stream <= 1'b0;
      send_left  <= '0;
      fetch_left <= '0;
      tx_counter <= '0;
      tx_en_quad <= 1'b0;
      xfer_done  <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      xfer_done <= 1'b0;
      if (cs) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (reg_gnt || stream_gnt) begin
              tx_en_quad <= en_quad;
              tx_counter <= en_quad ? SPI_TGT_QUAD : SPI_TGT_SINGLE;
              underflow  <= 1'b0;
              src_stream <= stream_gnt;
              send_left  <= stream_gnt ? stream_len : '0;
              fetch_left <= stream_gnt ? stream_len : '0;
              state      <= reg_gnt ? ST_LOAD : ST_PREFETCH;
            end
          end
          ST_PREFETCH: if (pop) state <= ST_LOAD;
          ST_LOAD:     state <= ST_SHIFT;
          ST_SHIFT: begin
            if (pop)
              fetch_left <= fetch_left - 1'b1;
            if (tx_done) begin
              if (send_left == '0) begin
                xfer_done <= 1'b1;
                state     <= ST_IDLE;
              end else begin
                send_left <= send_left - 1'b1;
                // A padded slot still consumes one fetch so later words keep their positions.
                if (!hold_full && !bypass) begin
                  underflow <= 1'b1;
                  if (fetch_left != '0) fetch_left <= fetch_left - 1'b1;
                end
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_device_tx_sched.sv
// Scoreboard bench for spi_device_tx_sched: stimulus queues expected shifter words,
// a monitor pops and compares them on every tx_data_valid.
module tb_spi_device_tx_sched;

  logic        sclk = 1'b0;
  logic        rst, cs, en_quad, reg_req, stream_req, stream_valid, tx_done;
  logic [31:0] reg_rdata, stream_data;
  logic [7:0]  stream_len;
  logic        reg_gnt, stream_gnt, stream_ready, tx_data_valid, tx_counter_upd;
  logic        tx_en_quad, busy, xfer_done, underflow;
  logic [31:0] tx_data;
  logic [7:0]  tx_counter;

  logic [31:0] exp_q[$];
  logic [31:0] fifo_q[$];
  int          tests = 0;
  int          fails = 0;
  int          valid_cnt = 0;
  int          done_cnt = 0;
  int          mark;

  always #5 sclk = ~sclk;

  spi_device_tx_sched #(.DATA_W(32), .LEN_W(8), .PAD_WORD(32'h0)) dut (
    .sclk(sclk), .rst(rst), .cs(cs), .en_quad(en_quad),
    .reg_req(reg_req), .reg_rdata(reg_rdata), .reg_gnt(reg_gnt),
    .stream_req(stream_req), .stream_len(stream_len), .stream_gnt(stream_gnt),
    .stream_data(stream_data), .stream_valid(stream_valid), .stream_ready(stream_ready),
    .tx_data(tx_data), .tx_data_valid(tx_data_valid), .tx_counter(tx_counter),
    .tx_counter_upd(tx_counter_upd), .tx_en_quad(tx_en_quad), .tx_done(tx_done),
    .busy(busy), .xfer_done(xfer_done), .underflow(underflow)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge sclk);
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
  endtask

  function automatic logic [63:0] all_out();
    return {15'd0, reg_gnt, stream_gnt, stream_ready, tx_data, tx_data_valid, tx_counter,
            tx_counter_upd, tx_en_quad, busy, xfer_done, underflow};
  endfunction

  task automatic monitor_loop();
    logic [31:0] e;
    forever begin
      at_neg();
      if (tx_data_valid) begin
        valid_cnt++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got %0h expected none", tx_data);
        end else begin
          e = exp_q.pop_front();
          chk("tx_data", {32'd0, tx_data}, {32'd0, e});
        end
      end
      if (xfer_done) done_cnt++;
    end
  endtask

  task automatic fifo_loop();
    forever begin
      @(posedge sclk);
      if (stream_valid && stream_ready && fifo_q.size() != 0) void'(fifo_q.pop_front());
      #2;
      stream_valid = (fifo_q.size() != 0);
      stream_data  = (fifo_q.size() != 0) ? fifo_q[0] : 32'hDEAD_BEEF;
    end
  endtask

  task automatic stimulus();
    rst = 1; cs = 1; en_quad = 0; reg_req = 0; stream_req = 0; tx_done = 0;
    reg_rdata = '0; stream_len = '0;
    repeat (3) step();
    at_neg();
    chk("reset_outputs", all_out(), 64'd0);
    step();
    rst = 0; cs = 0;
    step();

    // single register word
    reg_rdata = 32'hA5A5_0F0F; reg_req = 1; en_quad = 0;
    exp_q.push_back(32'hA5A5_0F0F);
    mark = done_cnt;
    at_neg();
    chk("reg_gnt", reg_gnt, 1);
    chk("reg_only_no_stream_gnt", stream_gnt, 0);
    step(); reg_req = 0;
    at_neg();
    chk("reg_tx_counter", tx_counter, 31);
    chk("reg_counter_upd", tx_counter_upd, 1);
    step(); step();
    pulse_done();
    at_neg();
    chk("reg_xfer_done", xfer_done, 1);
    chk("reg_busy_after", busy, 0);
    step(); step();
    chk("reg_done_pulses", done_cnt - mark, 1);

    // simultaneous requests: register first, stream right after
    reg_rdata = 32'h1111_2222; reg_req = 1; stream_req = 1; stream_len = 0;
    fifo_q.push_back(32'h3333_4444);
    exp_q.push_back(32'h1111_2222);
    exp_q.push_back(32'h3333_4444);
    at_neg();
    chk("prio_reg_gnt", reg_gnt, 1);
    chk("prio_stream_wait", stream_gnt, 0);
    step(); reg_req = 0;
    at_neg();
    chk("prio_no_stream_gnt_busy", stream_gnt, 0);
    step(); step();
    pulse_done();
    at_neg();
    chk("prio_reg_done", xfer_done, 1);
    chk("prio_stream_gnt", stream_gnt, 1);
    step(); stream_req = 0;
    at_neg();
    chk("prefetch_ready", stream_ready, 1);
    step(); step();
    pulse_done();
    step(); step();

    // quad stream of 4 words, FIFO full
    en_quad = 1; stream_len = 3; stream_req = 1;
    foreach (fifo_q[i]) ;
    for (int i = 0; i < 4; i++) begin
      fifo_q.push_back(32'hC0DE_0000 + 32'(i));
      exp_q.push_back(32'hC0DE_0000 + 32'(i));
    end
    mark = valid_cnt;
    at_neg();
    chk("quad_stream_gnt", stream_gnt, 1);
    step(); stream_req = 0; en_quad = 0;
    step();
    at_neg();
    chk("quad_tx_counter", tx_counter, 7);
    chk("quad_tx_en_quad", tx_en_quad, 1);
    step(); step(); step();
    for (int i = 0; i < 3; i++) begin
      pulse_done();
      step(); step();
    end
    chk("quad_counter_stable", {tx_en_quad, tx_counter}, {1'b1, 8'd7});
    pulse_done();
    step(); step();
    chk("quad_word_count", valid_cnt - mark, 4);
    chk("quad_no_underflow", underflow, 0);
    chk("quad_queue_drained", exp_q.size(), 0);

    // underflow: only word 0 available, 3 words requested
    en_quad = 0; stream_len = 2; stream_req = 1;
    fifo_q.push_back(32'h0BAD_F00D);
    exp_q.push_back(32'h0BAD_F00D);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    step(); stream_req = 0;
    step(); step(); step();
    pulse_done();
    at_neg();
    chk("underflow_set", underflow, 1);
    step();
    pulse_done();
    step();
    mark = done_cnt;
    pulse_done();
    step(); step();
    chk("underflow_done", done_cnt - mark, 1);
    chk("underflow_sticky", underflow, 1);

    // bypass: word 1 arrives in the same cycle as tx_done
    stream_len = 1; stream_req = 1;
    fifo_q.push_back(32'h1234_5678);
    exp_q.push_back(32'h1234_5678);
    exp_q.push_back(32'h9ABC_DEF0);
    step(); stream_req = 0;
    at_neg();
    chk("underflow_cleared_at_gnt", underflow, 0);
    step(); step(); step(); step();
    tx_done = 1;
    fifo_q.push_back(32'h9ABC_DEF0);
    step(); tx_done = 0;
    at_neg();
    chk("bypass_no_underflow", underflow, 0);
    chk("bypass_popped", fifo_q.size(), 0);
    step();
    pulse_done();
    step(); step();

    // cs abort at word 2 of 4
    stream_len = 3; stream_req = 1;
    for (int i = 0; i < 4; i++) fifo_q.push_back(32'hAB00_0000 + 32'(i));
    exp_q.push_back(32'hAB00_0000);
    exp_q.push_back(32'hAB00_0001);
    step(); stream_req = 0;
    step(); step(); step(); step();
    pulse_done();
    step(); step();
    mark = done_cnt;
    cs = 1;
    step();
    at_neg();
    chk("abort_busy", busy, 0);
    chk("abort_no_valid", tx_data_valid, 0);
    step(); cs = 0;
    fifo_q.delete();
    step(); step(); step();
    chk("abort_no_xfer_done", done_cnt - mark, 0);

    // reset while waiting in PREFETCH
    en_quad = 1; stream_len = 0; stream_req = 1;
    step(); stream_req = 0;
    step();
    at_neg();
    chk("prefetch_waiting", {busy, stream_ready}, 2'b11);
    step(); rst = 1;
    step();
    at_neg();
    chk("rst_prefetch_outputs", all_out(), 64'd0);
    step(); rst = 0;
    step(); step();
    chk("scoreboard_empty", exp_q.size(), 0);
  endtask

  initial begin
    stream_valid = 0;
    stream_data  = '0;
    fork
      monitor_loop();
      fifo_loop();
      stimulus();
    join_any
    disable fork;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
